sync_req_arbiter: RTL and testbench
===================================

// Module: sync_req_arbiter
// PURPOSE
//  Shares one resource among NumReq requesters whose request lines are asynchronous (pins or other
//  clock domains). Each line passes through its own SyncStages-deep synchronizer. A round-robin FSM
//  then grants exactly one requester at a time. It sits between the UDB pin/status synchronizers and
//  any shared datapath, such as a DMA trigger mux or a shared counter, and is clocked by the UDB clock.
// PARAMETERS
//  NumReq        4    number of requesters, range 2..8
//  SyncStages    2    flops per request synchronizer, range 2..3
//  TimeoutWidth  8    width of the grant-hold timeout counter
//  TimeoutCycles 200  maximum cycles in GRANT before a forced release; 0 disables the timeout
//  (localparam IdWidth = clog2(NumReq), with a minimum of 1)
// PORTS
//  clock       in   1          the single clock for the block; all state changes on the rising edge
//  reset       in   1          asynchronous, active-high; clears all state
//  req_in      in   NumReq     asynchronous level requests, one bit per requester
//  done        in   1          synchronous; the granted user releases the resource
//  grant       out  NumReq     one-hot grant vector; all zero when nothing is granted
//  grant_valid out  1          high whenever grant is non-zero
//  grant_id    out  IdWidth    index of the granted requester; holds the last winner when idle
//  busy        out  1          high in GRANT or RELEASE
//  timeout     out  1          one-cycle pulse when a grant is forcibly revoked
// BEHAVIOUR
//  Reset: every flop is cleared asynchronously.
//   - grant=0, grant_valid=0, grant_id=0, busy=0, timeout=0, and the FSM is in IDLE.
//   - rr_ptr=NumReq-1, so requester 0 has first priority after reset.
//  Synchronizers: req_s[i] is req_in[i] delayed by SyncStages flops; no logic sits between stages.
//  FSM states: IDLE, GRANT, RELEASE. All outputs are registered.
//  IDLE:
//   - If req_s is non-zero, pick the first set bit scanning from rr_ptr+1 upward with wrap-around.
//   - On that edge: go to GRANT, set grant/grant_id/grant_valid/busy, set rr_ptr to the winner.
//   - Load the timeout counter with 0.
//  GRANT:
//   - The counter increments each cycle, saturating at its maximum value.
//   - Leave GRANT when done=1, OR req_s[grant_id]=0 (requester withdrew),
//     OR (TimeoutCycles!=0 AND counter==TimeoutCycles-1).
//   - On leaving: clear grant and grant_valid and go to RELEASE.
//   - timeout=1 for that one cycle only when the timeout condition is the sole exit cause.
//  RELEASE:
//   - Exactly one cycle with grant=0 and busy=1; then return to IDLE. This gives a guaranteed
//     dead cycle between owners.
//  Latency:
//   - req_in rising to grant set: SyncStages+1 clocks when idle.
//   - done to grant clear: 1 clock.
//   - Minimum spacing between successive grants: 3 clocks.
//  Simultaneous events:
//   - done and withdraw in the same cycle are treated as a normal release (timeout=0).
//   - done and timeout in the same cycle: done wins (timeout=0).
//   - New requests arriving during GRANT or RELEASE are only evaluated in IDLE.
//   - done is ignored outside GRANT.
//  Fairness: a requester held continuously high receives a grant within NumReq arbitration rounds.
//  Reset mid-grant drops grant immediately (asynchronously); no timeout pulse is produced.
//  Glitches on req_in shorter than 1 clock may or may not register; a request must be held until
//  granted.
// TESTING
//  T1 reset:
//   - reset=1 with req_in=4'hF -> all outputs 0.
//   - Release reset -> grant=4'b0001 and grant_id=0 exactly 3 clocks later (SyncStages=2).
//  T2 round-robin:
//   - req_in=4'hF held, done pulsed 1 cycle after each grant.
//   - Grants must come in order 0,1,2,3,0, with a grant=0 cycle between each.
//  T3 withdraw:
//   - Grant requester 2, then drop req_in[2].
//   - grant clears SyncStages+1 clocks after the drop; timeout stays 0.
//  T4 timeout:
//   - TimeoutCycles=5, req_in=4'b0100 held, done=0.
//   - grant is high for exactly 5 cycles, timeout pulses once, then requester 2 is regranted.
//  T5 simultaneous:
//   - done and the timeout condition in the same cycle -> timeout=0, normal release.
//   - done asserted in IDLE -> no state change.
//  T6 reset mid-grant:
//   - Assert reset asynchronously between clock edges while grant=4'b1000.
//   - grant=0 before the next edge; after release, priority restarts at requester 0.

Source files
------------

// File: rtl/sync_req_arbiter.sv
// ----------------------------------------------------------------------------
// sync_req_arbiter
//   Grants one shared resource to one of NumReq asynchronous requesters.
//   Each request line first passes through its own SyncStages-deep flop
//   chain. A three-state round-robin FSM (IDLE -> GRANT -> RELEASE) then
//   hands out a one-hot grant. RELEASE always inserts one dead cycle
//   between owners.
//
//   Ports
//     clock        rising-edge clock for all state
//     reset        asynchronous, active-high; clears every flop
//     req_in       [NumReq]  asynchronous level requests
//     done         synchronous release from the current owner (GRANT only)
//     grant        [NumReq]  one-hot grant, zero when nothing is granted
//     grant_valid  high whenever grant is non-zero
//     grant_id     [IdWidth] index of the current/last winner
//     busy         high in GRANT or RELEASE
//     timeout      one-cycle pulse when a grant is forcibly revoked
// ----------------------------------------------------------------------------

// Per-requester synchronizer: a plain flop chain with no logic between stages.
module sync_req_arbiter_sync #(
    parameter int Stages = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [Stages-1:0] chain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[Stages-2:0], d};
    end

    assign q = chain[Stages-1];
endmodule

module sync_req_arbiter #(
    parameter int NumReq        = 4,
    parameter int SyncStages    = 2,
    parameter int TimeoutWidth  = 8,
    parameter int TimeoutCycles = 200,
    localparam int IdWidth      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NumReq-1:0]  req_in,
    input  logic               done,
    output logic [NumReq-1:0]  grant,
    output logic               grant_valid,
    output logic [IdWidth-1:0] grant_id,
    output logic               busy,
    output logic               timeout
);
    localparam bit                    ToEnable = (TimeoutCycles != 0);
    localparam logic [TimeoutWidth-1:0] ToLast = TimeoutWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                  state, state_nx;
    logic [NumReq-1:0]       req_s;
    logic [IdWidth-1:0]      rr_ptr, rr_ptr_nx;
    logic [TimeoutWidth-1:0] cnt, cnt_nx;
    logic [NumReq-1:0]       grant_nx;
    logic                    grant_valid_nx;
    logic [IdWidth-1:0]      grant_id_nx;
    logic                    busy_nx;
    logic                    timeout_nx;

    logic                    pick_vld;
    logic [IdWidth-1:0]      pick_id;
    logic                    withdraw;
    logic                    to_hit;

    // ------------------------------------------------------------------
    // One synchronizer per requester
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NumReq; g++) begin : g_sync
        sync_req_arbiter_sync #(.Stages(SyncStages)) u_sync (
            .clock (clock),
            .reset (reset),
            .d     (req_in[g]),
            .q     (req_s[g])
        );
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first set bit strictly above rr_ptr, otherwise the
    // first set bit at or below it (the wrap-around half of the scan).
    // ------------------------------------------------------------------
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (!pick_vld && req_s[i] && (i > int'(rr_ptr))) begin
                pick_vld = 1'b1;
                pick_id  = IdWidth'(i);
            end
        end
        for (int i = 0; i < NumReq; i++) begin
            if (!pick_vld && req_s[i] && (i <= int'(rr_ptr))) begin
                pick_vld = 1'b1;
                pick_id  = IdWidth'(i);
            end
        end
    end

    assign withdraw = ~req_s[grant_id];
    assign to_hit   = ToEnable && (cnt == ToLast);

    // ------------------------------------------------------------------
    // FSM next-state and registered-output values
    // ------------------------------------------------------------------
    always_comb begin
        state_nx       = state;
        rr_ptr_nx      = rr_ptr;
        cnt_nx         = cnt;
        grant_nx       = grant;
        grant_valid_nx = grant_valid;
        grant_id_nx    = grant_id;
        busy_nx        = busy;
        timeout_nx     = 1'b0;

        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nx       = S_GRANT;
                    grant_nx       = NumReq'(1) << pick_id;
                    grant_valid_nx = 1'b1;
                    grant_id_nx    = pick_id;
                    busy_nx        = 1'b1;
                    rr_ptr_nx      = pick_id;
                    cnt_nx         = '0;
                end
            end
            S_GRANT: begin
                cnt_nx = (cnt == '1) ? cnt : cnt + 1'b1;
                if (done || withdraw || to_hit) begin
                    state_nx       = S_RELEASE;
                    grant_nx       = '0;
                    grant_valid_nx = 1'b0;
                    // Only flag a forced revoke when nothing else ended the grant.
                    timeout_nx     = to_hit && !done && !withdraw;
                end
            end
            S_RELEASE: begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx       = S_IDLE;
                grant_nx       = '0;
                grant_valid_nx = 1'b0;
                busy_nx        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= IdWidth'(NumReq - 1);
            cnt         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nx;
            rr_ptr      <= rr_ptr_nx;
            cnt         <= cnt_nx;
            grant       <= grant_nx;
            grant_valid <= grant_valid_nx;
            grant_id    <= grant_id_nx;
            busy        <= busy_nx;
            timeout     <= timeout_nx;
        end
    end
endmodule

// File: tb/tb_sync_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sync_req_arbiter
//   Directed bench for sync_req_arbiter (NumReq=4, SyncStages=2,
//   TimeoutCycles=5). Covers reset, round-robin order, withdraw, timeout,
//   done/timeout collision, done in IDLE and asynchronous reset mid-grant.
// ----------------------------------------------------------------------------
module tb_sync_req_arbiter;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req_in;
    logic       done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    sync_req_arbiter #(
        .NumReq        (4),
        .SyncStages    (2),
        .TimeoutWidth  (8),
        .TimeoutCycles (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_in      (req_in),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout     (timeout)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // grant_valid is always expected to track |grant
    task automatic chk_out(input string tag, input logic [3:0] g, input logic b, input logic t);
        check({tag, " grant"},       32'(grant),       32'(g));
        check({tag, " grant_valid"}, 32'(grant_valid), 32'(|g));
        check({tag, " busy"},        32'(busy),        32'(b));
        check({tag, " timeout"},     32'(timeout),     32'(t));
    endtask

    initial begin
        // ---------------- T1 reset ----------------
        reset  = 1'b1;
        req_in = 4'hF;
        done   = 1'b0;
        tick();
        chk_out("t1 in reset", 4'b0000, 1'b0, 1'b0);
        check("t1 in reset id", 32'(grant_id), 32'd0);
        reset = 1'b0;
        tick();
        chk_out("t1 +1", 4'b0000, 1'b0, 1'b0);
        tick();
        chk_out("t1 +2", 4'b0000, 1'b0, 1'b0);
        tick();
        chk_out("t1 +3", 4'b0001, 1'b1, 1'b0);
        check("t1 +3 id", 32'(grant_id), 32'd0);

        // ---------------- T2 round-robin ----------------
        for (int k = 1; k <= 4; k++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            chk_out($sformatf("t2 release %0d", k), 4'b0000, 1'b1, 1'b0);
            tick();
            chk_out($sformatf("t2 dead %0d", k), 4'b0000, 1'b0, 1'b0);
            tick();
            chk_out($sformatf("t2 grant %0d", k), 4'(1 << (k % 4)), 1'b1, 1'b0);
            check($sformatf("t2 id %0d", k), 32'(grant_id), 32'(k % 4));
        end

        // Release requester 0 and let everything drain to IDLE.
        done   = 1'b1;
        req_in = 4'h0;
        tick();
        done = 1'b0;
        repeat (3) tick();
        chk_out("t2 drained", 4'b0000, 1'b0, 1'b0);

        // ---------------- T3 withdraw ----------------
        req_in = 4'b0100;
        tick();
        tick();
        chk_out("t3 pre", 4'b0000, 1'b0, 1'b0);
        tick();
        chk_out("t3 grant", 4'b0100, 1'b1, 1'b0);
        check("t3 id", 32'(grant_id), 32'd2);
        req_in = 4'b0000;
        tick();
        chk_out("t3 drop+1", 4'b0100, 1'b1, 1'b0);
        tick();
        chk_out("t3 drop+2", 4'b0100, 1'b1, 1'b0);
        tick();
        chk_out("t3 drop+3", 4'b0000, 1'b1, 1'b0);
        tick();
        chk_out("t3 idle", 4'b0000, 1'b0, 1'b0);
        check("t3 id hold", 32'(grant_id), 32'd2);

        // ---------------- T4 timeout ----------------
        req_in = 4'b0100;
        repeat (3) tick();
        chk_out("t4 grant", 4'b0100, 1'b1, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk_out($sformatf("t4 hold %0d", c), 4'b0100, 1'b1, 1'b0);
        end
        tick();
        chk_out("t4 revoke", 4'b0000, 1'b1, 1'b1);
        tick();
        chk_out("t4 idle", 4'b0000, 1'b0, 1'b0);
        tick();
        chk_out("t4 regrant", 4'b0100, 1'b1, 1'b0);
        check("t4 regrant id", 32'(grant_id), 32'd2);

        // ---------------- T5 done collides with timeout ----------------
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk_out($sformatf("t5 hold %0d", c), 4'b0100, 1'b1, 1'b0);
        end
        done   = 1'b1;
        req_in = 4'b0000;
        tick();
        done = 1'b0;
        chk_out("t5 done wins", 4'b0000, 1'b1, 1'b0);
        tick();
        chk_out("t5 idle", 4'b0000, 1'b0, 1'b0);

        // done in IDLE must be ignored
        done = 1'b1;
        tick();
        chk_out("t5 done idle 1", 4'b0000, 1'b0, 1'b0);
        tick();
        done = 1'b0;
        chk_out("t5 done idle 2", 4'b0000, 1'b0, 1'b0);
        check("t5 id hold", 32'(grant_id), 32'd2);

        // ---------------- T6 reset mid-grant ----------------
        req_in = 4'b1000;
        repeat (3) tick();
        chk_out("t6 grant", 4'b1000, 1'b1, 1'b0);
        check("t6 id", 32'(grant_id), 32'd3);
        #3;
        reset = 1'b1;
        #1;
        chk_out("t6 async reset", 4'b0000, 1'b0, 1'b0);
        check("t6 async reset id", 32'(grant_id), 32'd0);
        req_in = 4'hF;
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk_out("t6 post +2", 4'b0000, 1'b0, 1'b0);
        tick();
        chk_out("t6 post +3", 4'b0001, 1'b1, 1'b0);
        check("t6 post id", 32'(grant_id), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
